// File: rtl/vmem_db.sv
// Double-buffered pixel frame memory: the front bank feeds the display with a registered read,
// writes and a full-bank fill go to the back bank, and front/back swap only on frame boundaries.
module vmem_db #(
  parameter int H_BITS     = 10,
  parameter int V_BITS     = 9,
  parameter int PIX_W      = 24,
  parameter int DOUBLE_BUF = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [H_BITS-1:0] rd_h_addr,
  input  logic [V_BITS-1:0] rd_v_addr,
  output logic [PIX_W-1:0]  rd_data,
  input  logic              frame_start,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [H_BITS-1:0] wr_h_addr,
  input  logic [V_BITS-1:0] wr_v_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              swap_req,
  output logic              swap_pending,
  input  logic              fill_start,
  input  logic [PIX_W-1:0]  fill_color,
  output logic              fill_busy,
  output logic              front_sel
);

  localparam int   A_W   = H_BITS + V_BITS;
  localparam int   DEPTH = 1 << A_W;
  localparam logic DB    = (DOUBLE_BUF != 0);

  typedef enum logic {
    S_IDLE,
    S_FILL
  } fill_state_e;

  // Reset asserts immediately but releases two edges later, so no state moves on the first edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_rst_sync <= 2'b00;
    else         r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  fill_state_e            r_state;
  fill_state_e            w_state_nxt;
  logic [A_W-1:0]         r_fill_addr;
  logic [A_W-1:0]         w_fill_addr_nxt;
  logic [PIX_W-1:0]       r_fill_color;
  logic [PIX_W-1:0]       w_fill_color_nxt;
  logic                   r_front_sel;
  logic                   r_swap_pending;
  logic [PIX_W-1:0]       r_rd_data;

  // NOTE: every always_comb output gets its hold value first, so no path can infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_fill_addr_nxt  = r_fill_addr;
    w_fill_color_nxt = r_fill_color;
    case (r_state)
      S_IDLE: begin
        if (fill_start) begin
          w_state_nxt      = S_FILL;
          w_fill_addr_nxt  = '0;
          w_fill_color_nxt = fill_color;
        end
      end
      S_FILL: begin
        w_fill_addr_nxt = r_fill_addr + 1'b1;
        if (&r_fill_addr) w_state_nxt = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state      <= S_IDLE;
      r_fill_addr  <= '0;
      r_fill_color <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_fill_addr  <= w_fill_addr_nxt;
      r_fill_color <= w_fill_color_nxt;
    end
  end

  logic w_fill_busy;
  logic w_swap_fire;

  assign w_fill_busy = (r_state == S_FILL);
  // A swap never lands mid-fill, otherwise the fill would spill into the displayed bank.
  assign w_swap_fire = DB & frame_start & (swap_req | r_swap_pending) & ~w_fill_busy;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_front_sel    <= 1'b0;
      r_swap_pending <= 1'b0;
    end else if (w_swap_fire) begin
      r_front_sel    <= ~r_front_sel;
      r_swap_pending <= 1'b0;
    end else if (DB & swap_req) begin
      r_swap_pending <= 1'b1;
    end
  end

  logic [PIX_W-1:0] r_mem [2*DEPTH];
  logic             w_wr_bank;
  logic             w_rd_bank;
  logic             w_mem_we;
  logic [A_W:0]     w_mem_waddr;
  logic [PIX_W-1:0] w_mem_wdata;

  assign w_wr_bank   = DB & ~r_front_sel;
  assign w_rd_bank   = DB & r_front_sel;
  assign w_mem_we    = w_fill_busy | (wr_valid & ~w_fill_busy);
  assign w_mem_waddr = w_fill_busy ? {w_wr_bank, r_fill_addr}
                                   : {w_wr_bank, wr_h_addr, wr_v_addr};
  assign w_mem_wdata = w_fill_busy ? r_fill_color : wr_data;

  // NOTE: pixel storage has no reset; clearing it would need a sweep, and a reset mid-fill must leave it as-is.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
  end

  // Sampling front_sel before it toggles keeps the read in the swap cycle on the old bank.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_rd_data <= '0;
    else          r_rd_data <= r_mem[{w_rd_bank, rd_h_addr, rd_v_addr}];
  end

  assign rd_data      = r_rd_data;
  assign wr_ready     = ~w_fill_busy;
  assign fill_busy    = w_fill_busy;
  assign swap_pending = r_swap_pending;
  assign front_sel    = r_front_sel;

endmodule

// File: tb/tb_vmem_db.sv
// Directed bench for vmem_db at 3x2 address bits, 8-bit pixels, double-buffered (32 pixels per bank).
module tb_vmem_db;

  logic       clk;
  logic       resetn;
  logic [2:0] rd_h_addr;
  logic [1:0] rd_v_addr;
  logic [7:0] rd_data;
  logic       frame_start;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_h_addr;
  logic [1:0] wr_v_addr;
  logic [7:0] wr_data;
  logic       swap_req;
  logic       swap_pending;
  logic       fill_start;
  logic [7:0] fill_color;
  logic       fill_busy;
  logic       front_sel;

  int checks = 0;
  int errors = 0;

  vmem_db #(
    .H_BITS    (3),
    .V_BITS    (2),
    .PIX_W     (8),
    .DOUBLE_BUF(1)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .rd_h_addr   (rd_h_addr),
    .rd_v_addr   (rd_v_addr),
    .rd_data     (rd_data),
    .frame_start (frame_start),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_h_addr   (wr_h_addr),
    .wr_v_addr   (wr_v_addr),
    .wr_data     (wr_data),
    .swap_req    (swap_req),
    .swap_pending(swap_pending),
    .fill_start  (fill_start),
    .fill_color  (fill_color),
    .fill_busy   (fill_busy),
    .front_sel   (front_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic read_px(input logic [2:0] h, input logic [1:0] v);
    rd_h_addr = h;
    rd_v_addr = v;
    tick();
  endtask

  task automatic wait_fill_idle(input string tag);
    for (int i = 0; i < 64; i++) begin
      if (!fill_busy) break;
      tick();
    end
    check(tag, fill_busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         busy_cycles;
    int         ready_bad;
    logic [4:0] av;

    resetn      = 1'b0;
    rd_h_addr   = '0;
    rd_v_addr   = '0;
    frame_start = 1'b0;
    wr_valid    = 1'b0;
    wr_h_addr   = '0;
    wr_v_addr   = '0;
    wr_data     = '0;
    swap_req    = 1'b0;
    fill_start  = 1'b0;
    fill_color  = '0;

    repeat (3) tick();
    check("rst_rd_data", rd_data, 0);
    check("rst_front_sel", front_sel, 0);
    check("rst_swap_pending", swap_pending, 0);
    check("rst_fill_busy", fill_busy, 0);
    check("rst_wr_ready", wr_ready, 1);

    // A swap presented on the first edge after release must not take effect.
    resetn      = 1'b1;
    swap_req    = 1'b1;
    frame_start = 1'b1;
    tick();
    swap_req    = 1'b0;
    frame_start = 1'b0;
    check("sync_front_sel", front_sel, 0);
    check("sync_pending", swap_pending, 0);
    repeat (2) tick();

    // Basic write, swap, read.
    wr_valid  = 1'b1;
    wr_h_addr = 3'd5;
    wr_v_addr = 2'd2;
    wr_data   = 8'hA5;
    tick();
    wr_valid = 1'b0;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    check("req_pending", swap_pending, 1);
    check("req_front_hold", front_sel, 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("swap1_front", front_sel, 1);
    check("swap1_pending", swap_pending, 0);
    read_px(3'd5, 2'd2);
    check("read_a5", rd_data, 8'hA5);

    // Full fill with writes attempted throughout the busy window.
    fill_color = 8'h3C;
    fill_start = 1'b1;
    tick();
    fill_start  = 1'b0;
    fill_color  = 8'h00;
    busy_cycles = 0;
    ready_bad   = 0;
    wr_valid    = 1'b1;
    wr_h_addr   = 3'd5;
    wr_v_addr   = 2'd2;
    wr_data     = 8'hEE;
    for (int i = 0; i < 40; i++) begin
      if (fill_busy) begin
        busy_cycles++;
        if (wr_ready) ready_bad++;
      end else begin
        wr_valid = 1'b0;
      end
      tick();
    end
    wr_valid = 1'b0;
    check("fill_busy_cycles", busy_cycles, 32);
    check("fill_ready_low", ready_bad, 0);

    // Read in the toggling cycle sees the old front bank, the next one the new bank.
    rd_h_addr   = 3'd5;
    rd_v_addr   = 2'd2;
    swap_req    = 1'b1;
    frame_start = 1'b1;
    tick();
    swap_req    = 1'b0;
    frame_start = 1'b0;
    check("swap2_front", front_sel, 0);
    check("swap_edge_old_bank", rd_data, 8'hA5);
    tick();
    check("swap_new_bank", rd_data, 8'h3C);
    for (int a = 0; a < 32; a++) begin
      av = a[4:0];
      read_px(av[4:2], av[1:0]);
      check($sformatf("fill3c_addr%0d", a), rd_data, 8'h3C);
    end

    // Swap requested during a fill is deferred past a frame_start that arrives while busy.
    fill_color = 8'h55;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    swap_req   = 1'b1;
    tick();
    swap_req = 1'b0;
    check("defer_pending_set", swap_pending, 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("defer_front_hold", front_sel, 0);
    check("defer_pending_hold", swap_pending, 1);
    wait_fill_idle("fill55_done");
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("defer_front_toggle", front_sel, 1);
    check("defer_pending_clr", swap_pending, 0);
    read_px(3'd0, 2'd0);
    check("fill55_first", rd_data, 8'h55);
    read_px(3'd7, 2'd3);
    check("fill55_last", rd_data, 8'h55);

    // Write and fill_start in the same cycle: the fill overwrites the write.
    wr_valid   = 1'b1;
    wr_h_addr  = 3'd1;
    wr_v_addr  = 2'd1;
    wr_data    = 8'h11;
    fill_color = 8'h00;
    fill_start = 1'b1;
    tick();
    wr_valid   = 1'b0;
    fill_start = 1'b0;
    check("collide_busy", fill_busy, 1);
    check("collide_ready", wr_ready, 0);
    wait_fill_idle("fill00_done");
    swap_req    = 1'b1;
    frame_start = 1'b1;
    tick();
    swap_req    = 1'b0;
    frame_start = 1'b0;
    check("swap3_front", front_sel, 0);
    read_px(3'd1, 2'd1);
    check("collide_overwritten", rd_data, 8'h00);

    // Two requests then two frame_starts toggle once.
    swap_req = 1'b1;
    tick();
    tick();
    swap_req = 1'b0;
    check("dbl_req_pending", swap_pending, 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("dbl_first_front", front_sel, 1);
    check("dbl_first_pending", swap_pending, 0);
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("dbl_second_front", front_sel, 1);

    // Reset in the middle of a fill aborts it without a clock edge.
    rd_h_addr  = 3'd0;
    rd_v_addr  = 2'd0;
    fill_color = 8'h77;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    repeat (10) tick();
    check("midfill_busy", fill_busy, 1);
    check("midfill_rd_data", rd_data, 8'h55);
    resetn = 1'b0;
    #1;
    check("async_fill_busy", fill_busy, 0);
    check("async_front_sel", front_sel, 0);
    check("async_rd_data", rd_data, 0);
    check("async_pending", swap_pending, 0);
    check("async_wr_ready", wr_ready, 1);
    tick();
    tick();
    resetn = 1'b1;
    repeat (3) tick();
    check("post_rst_idle", fill_busy, 0);
    read_px(3'd2, 2'd1);
    check("partial_addr9", rd_data, 8'h77);
    read_px(3'd2, 2'd2);
    check("partial_addr10", rd_data, 8'h00);

    wr_valid  = 1'b1;
    wr_h_addr = 3'd3;
    wr_v_addr = 2'd0;
    wr_data   = 8'h9A;
    tick();
    wr_valid    = 1'b0;
    swap_req    = 1'b1;
    frame_start = 1'b1;
    tick();
    swap_req    = 1'b0;
    frame_start = 1'b0;
    check("post_rst_front", front_sel, 1);
    read_px(3'd3, 2'd0);
    check("post_rst_write", rd_data, 8'h9A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vmem_db.md
VMEM_DB -- requirements
Module: vmem_db

Interface
REQ-001 Parameter H_BITS, default 10: horizontal pixel address width.
REQ-002 Parameter V_BITS, default 9: vertical pixel address width.
REQ-003 Parameter PIX_W, default 24: pixel width (RGB888 at default).
REQ-004 Parameter DOUBLE_BUF, default 1: 1 = two banks (front/back); 0 = single bank.
REQ-005 clk  in  1  sole clock; VGA pixel clock domain.
REQ-006 resetn  in  1  asynchronous, active-low reset.
REQ-007 rd_h_addr  in  H_BITS  display read column.
REQ-008 rd_v_addr  in  V_BITS  display read row.
REQ-009 rd_data  out  PIX_W  registered pixel from the front bank.
REQ-010 frame_start  in  1  one-cycle pulse at start of each frame.
REQ-011 wr_valid  in  1  pixel write request.
REQ-012 wr_ready  out  1  write accepted when wr_valid & wr_ready.
REQ-013 wr_h_addr, wr_v_addr  in  H_BITS, V_BITS  write pixel location.
REQ-014 wr_data  in  PIX_W  write pixel value.
REQ-015 swap_req  in  1  one-cycle pulse requesting a front/back swap.
REQ-016 swap_pending  out  1  swap requested but not yet applied.
REQ-017 fill_start  in  1  one-cycle pulse: fill the back bank with fill_color.
REQ-018 fill_color  in  PIX_W  fill value, sampled with fill_start.
REQ-019 fill_busy  out  1  fill engine active.
REQ-020 front_sel  out  1  index of the bank currently displayed.

Function
REQ-021 Bank address SHALL be {h_addr, v_addr}; depth per bank SHALL be 2^(H_BITS+V_BITS).
REQ-022 rd_data SHALL equal front_bank[{rd_h_addr, rd_v_addr}] one cycle after the address is presented (latency 1, read every cycle, no handshake).
REQ-023 Accepted writes SHALL update the back bank (bank !front_sel) at the next clk edge; with DOUBLE_BUF=0, reads and writes SHALL use the single bank.
REQ-024 wr_ready SHALL be combinationally !fill_busy; no write SHALL be lost or applied while wr_ready=0.
REQ-025 Fill FSM states IDLE and FILL; IDLE->FILL on fill_start, which latches fill_color and clears the address counter to 0.
REQ-026 In FILL, the FSM SHALL write the latched color to one back-bank address per cycle in ascending order, then return to IDLE after address 2^(H_BITS+V_BITS)-1; fill_busy=1 for exactly 2^(H_BITS+V_BITS) cycles.
REQ-027 fill_start while fill_busy=1 SHALL be ignored.
REQ-028 fill_start in the same cycle as an accepted write: the write SHALL complete and the fill SHALL begin the next cycle, overwriting it.
REQ-029 swap_req SHALL set swap_pending; a second swap_req while pending SHALL have no additional effect.
REQ-030 On a frame_start cycle with swap_pending=1 (or swap_req=1) and fill_busy=0, front_sel SHALL toggle at that edge and swap_pending SHALL clear.
REQ-031 If fill_busy=1 at frame_start, the swap SHALL be deferred to the first frame_start after the fill completes.
REQ-032 A read presented in the cycle of the toggling edge SHALL use the old front bank; subsequent reads SHALL use the new front bank.
REQ-033 With DOUBLE_BUF=0, swap_req SHALL be ignored; swap_pending and front_sel SHALL remain 0.

Reset
REQ-034 On resetn=0: rd_data=0, front_sel=0, swap_pending=0, fill_busy=0, FSM=IDLE, fill counter=0, immediately and asynchronously.
REQ-035 Memory contents SHALL NOT be reset; reset during FILL SHALL abort the fill, leaving the back bank partially filled.
REQ-036 Reset release SHALL be synchronised so that the first state change occurs no earlier than the second clk edge after deassertion.

Verification (H_BITS=3, V_BITS=2, PIX_W=8, DOUBLE_BUF=1; depth 32)
REQ-037 Write 0xA5 to (h=5,v=2), swap_req, frame_start; read (5,2) -> rd_data=0xA5 one cycle later, front_sel=1, swap_pending=0.
REQ-038 fill_start with color 0x3C -> fill_busy=1 for exactly 32 cycles, wr_ready=0 throughout; after swap, all 32 reads return 0x3C.
REQ-039 swap_req during fill, frame_start while busy -> front_sel unchanged, swap_pending=1; next frame_start after fill -> front_sel toggles.
REQ-040 Write (1,1)=0x11 and fill_start same cycle with color 0x00 -> after fill and swap, (1,1) reads 0x00.
REQ-041 Assert resetn=0 mid-fill (cycle 10) -> fill_busy=0, front_sel=0, rd_data=0 without waiting for a clk edge; after release, writes accepted.
REQ-042 Two swap_req pulses, then two frame_start pulses -> front_sel toggles once only.
